// File: rtl/rv32imc_types.sv
// Shared types for the rv32imc core memory path.
// Holds the arbiter state enum, request bundle and mask constant.
package rv32imc_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IMEM,
    ARB_DMEM
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  parameter logic [3:0] ARB_NO_MASK = 4'b0;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select for mem_port_arbiter: dmem first, optional anti-starve.
// In: arb_en (arbiter idle), imem_req, dmem_req. Out: grant_imem, grant_dmem.
// MEM_ARB_ANTI_STARVE_EN adds clk/rst and a dmem streak counter.
module mem_arb_grant
  import rv32imc_types::*;
#(
  parameter int DMEM_STREAK_MAX = 4,
  parameter int STREAK_W        = 3
) (
`ifdef MEM_ARB_ANTI_STARVE_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic arb_en,
  input  logic imem_req,
  input  logic dmem_req,
  output logic grant_imem,
  output logic grant_dmem
);

  if (2**STREAK_W <= DMEM_STREAK_MAX) begin : g_bad_cfg
    $error("STREAK_W too narrow for DMEM_STREAK_MAX");
  end

`ifdef MEM_ARB_ANTI_STARVE_EN

  localparam logic [STREAK_W-1:0] STREAK_MAX =
    STREAK_W'(DMEM_STREAK_MAX);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                imem_wins;

  always_comb begin
    imem_wins  = imem_req &&
                 (!dmem_req || streak_q == STREAK_MAX);
    grant_imem = arb_en && imem_wins;
    grant_dmem = arb_en && dmem_req && !imem_wins;
    streak_d   = streak_q;
    unique case (1'b1)
      grant_imem:
        streak_d = '0;
      grant_dmem && imem_req:
        streak_d = (streak_q == STREAK_MAX) ?
                   streak_q : streak_q + 1'b1;
      grant_dmem && !imem_req:
        streak_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

`else

  // A dmem stall freezes the whole pipe, so dmem always goes first.
  assign grant_imem = arb_en && imem_req && !dmem_req;
  assign grant_dmem = arb_en && dmem_req;

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between imem and dmem, one txn at a time.
// Ports: imem_*/dmem_* upstream, mem_* downstream; optional MEM_ARB_ANTI_STARVE_EN.
module mem_port_arbiter
  import rv32imc_types::*;
#(
  parameter int DMEM_STREAK_MAX = 4,
  parameter int STREAK_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  arb_state_t state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       imem_req, dmem_req;
  logic       grant_imem, grant_dmem;
  logic       arb_en;

  assign imem_req = imem_rmask != ARB_NO_MASK;
  assign dmem_req = (dmem_rmask | dmem_wmask) != ARB_NO_MASK;
  assign arb_en   = state_q == ARB_IDLE;

  mem_arb_grant #(
    .DMEM_STREAK_MAX(DMEM_STREAK_MAX),
    .STREAK_W       (STREAK_W)
  ) u_grant (
`ifdef MEM_ARB_ANTI_STARVE_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .arb_en    (arb_en),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .grant_imem(grant_imem),
    .grant_dmem(grant_dmem)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_dmem) begin
          state_d = ARB_DMEM;
          req_d   = '{addr:  dmem_addr,
                      rmask: dmem_rmask,
                      wmask: dmem_wmask,
                      wdata: dmem_wdata};
        end else if (grant_imem) begin
          state_d = ARB_IMEM;
          req_d   = '{addr:  imem_addr,
                      rmask: imem_rmask,
                      wmask: ARB_NO_MASK,
                      wdata: '0};
        end
      end
      ARB_IMEM, ARB_DMEM: begin
        // Masks drop on completion; addr/wdata linger.
        if (mem_resp) begin
          state_d     = ARB_IDLE;
          req_d.rmask = ARB_NO_MASK;
          req_d.wmask = ARB_NO_MASK;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign mem_addr   = req_q.addr;
  assign mem_rmask  = req_q.rmask;
  assign mem_wmask  = req_q.wmask;
  assign mem_wdata  = req_q.wdata;

  assign imem_resp  = (state_q == ARB_IMEM) && mem_resp;
  assign dmem_resp  = (state_q == ARB_DMEM) && mem_resp;
  assign imem_rdata = imem_resp ? mem_rdata : '0;
  assign dmem_rdata = dmem_resp ? mem_rdata : '0;

  a_idle_resp: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == ARB_IDLE) |-> !mem_resp
  ) else $warning("mem_resp while idle ignored");

  a_imem_hold: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == ARB_IMEM) |-> imem_req
  ) else $error("imem request dropped while owned");

  a_dmem_hold: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == ARB_DMEM) |-> dmem_req
  ) else $error("dmem request dropped while owned");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DMEM_STREAK_MAX(4),
    .STREAK_W       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata),
    .imem_resp (imem_resp),
    .dmem_addr (dmem_addr),
    .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_resp (dmem_resp),
    .mem_addr  (mem_addr),
    .mem_rmask (mem_rmask),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  typedef struct {
    logic [1:0]  port;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gap;
  } exp_t;

  localparam logic [1:0] P_I = 2'b10;
  localparam logic [1:0] P_D = 2'b01;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   mem_lat = 1;
  logic idle_pulse = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h0000_1013;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  task automatic push(input logic [1:0] p, input logic [31:0] a,
                      input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int gap);
    exp_t e;
    e.port = p; e.addr = a; e.rmask = rm; e.wmask = wm;
    e.wdata = wd; e.rdata = rd; e.gap = gap;
    sb.push_back(e);
  endtask

  // Downstream memory: resp mem_lat cycles after a request appears.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp = 1'b0;
      mem_rdata = '0;
      if (rst) begin
        wcnt = 0;
      end else if (idle_pulse) begin
        mem_resp = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end else if ((mem_rmask | mem_wmask) != 4'h0) begin
        if (wcnt >= mem_lat - 1) begin
          mem_resp = 1'b1;
          mem_rdata = mem_val(mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    int   cyc, issue_cyc, last_resp;
    logic act, prev_act;
    exp_t e;
    logic [31:0] own_rd, oth_rd;
    cyc = 0; issue_cyc = 0; last_resp = 0; prev_act = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_act = 1'b0;
      end else begin
        act = (mem_rmask | mem_wmask) != 4'h0;
        if (act && !prev_act) issue_cyc = cyc;
        prev_act = act;
        if (imem_resp || dmem_resp) begin
          if (sb.size() == 0) begin
            chk("spurious_resp", {30'b0, imem_resp, dmem_resp}, '0);
          end else begin
            e = sb.pop_front();
            own_rd = imem_resp ? imem_rdata : dmem_rdata;
            oth_rd = imem_resp ? dmem_rdata : imem_rdata;
            chk("resp_port", {30'b0, imem_resp, dmem_resp},
                {30'b0, e.port});
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_rmask", {28'b0, mem_rmask}, {28'b0, e.rmask});
            chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, e.wmask});
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("owner_rdata", own_rd, e.rdata);
            chk("other_rdata", oth_rd, '0);
            if (e.gap >= 0)
              chk("issue_gap", 32'(issue_cyc - last_resp), 32'(e.gap));
          end
          last_resp = cyc;
        end
      end
    end
  end

  task automatic wait_resp(input logic is_i, input string n);
    int k;
    logic got;
    k = 0;
    got = 1'b0;
    do begin
      @(negedge clk);
      k++;
      got = is_i ? imem_resp : dmem_resp;
    end while (!got && k < 60);
    if (!got) begin
      n_total++;
      $display("FAIL %s_timeout: got no resp want resp", n);
    end
  endtask

  task automatic do_imem(input logic [31:0] a);
    imem_addr  = a;
    imem_rmask = 4'hF;
    wait_resp(1'b1, "imem");
    @(posedge clk); #1;
    imem_rmask = 4'h0;
  endtask

  task automatic do_dmem(input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd);
    dmem_addr  = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    wait_resp(1'b0, "dmem");
    @(posedge clk); #1;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
  endtask

  function automatic logic [31:0] d_addr(input int k);
    return 32'h0000_3000 + 32'(4 * k);
  endfunction
  function automatic logic [3:0] d_rm(input int k);
    return (k % 2 == 0) ? 4'hF : 4'h0;
  endfunction
  function automatic logic [3:0] d_wm(input int k);
    return (k % 2 == 1) ? 4'hC : 4'h0;
  endfunction
  function automatic logic [31:0] d_wd(input int k);
    return 32'hA5A5_0000 + 32'(k);
  endfunction

  initial begin
    logic [31:0] a0, w0;
    logic [31:0] i_addr[2];
`ifdef MEM_ARB_ANTI_STARVE_EN
    int ord[10] = '{0, 1, 2, 3, -1, 4, 5, 6, 7, -2};
`else
    int ord[10] = '{0, 1, 2, 3, 4, 5, 6, 7, -1, -2};
`endif
    i_addr[0] = 32'h0000_1100;
    i_addr[1] = 32'h0000_1104;

    rst = 1'b1;
    imem_addr = '0; imem_rmask = '0;
    dmem_addr = '0; dmem_rmask = '0;
    dmem_wmask = '0; dmem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_addr", mem_addr, '0);
    chk("rst_masks", {24'b0, mem_rmask, mem_wmask}, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_resps", {30'b0, imem_resp, dmem_resp}, '0);
    chk("rst_rdata", imem_rdata | dmem_rdata, '0);
    rst = 1'b0;

    // Lone imem read, 3-cycle memory
    @(posedge clk); #1;
    mem_lat = 3;
    push(P_I, 32'h0000_1000, 4'hF, 4'h0, '0, 32'h0000_0013, -1);
    imem_addr = 32'h0000_1000;
    imem_rmask = 4'hF;
    @(negedge clk);
    chk("t1_rmask_N", {28'b0, mem_rmask}, 32'h0);
    @(negedge clk);
    chk("t1_rmask_N1", {28'b0, mem_rmask}, 32'hF);
    wait_resp(1'b1, "t1_imem");
    @(posedge clk); #1;
    imem_rmask = 4'h0;
    mem_lat = 1;

    // Simultaneous: dmem write first, imem right after
    repeat (2) @(posedge clk); #1;
    push(P_D, 32'h0000_2000, 4'h0, 4'h3, 32'hDEAD_BEEF,
         mem_val(32'h0000_2000), -1);
    push(P_I, 32'h0000_1004, 4'hF, 4'h0, '0,
         mem_val(32'h0000_1004), 2);
    fork
      do_imem(32'h0000_1004);
      do_dmem(32'h0000_2000, 4'h0, 4'h3, 32'hDEAD_BEEF);
    join

    // mem_resp pulsed in IDLE
    repeat (2) @(negedge clk);
    a0 = mem_addr;
    w0 = mem_wdata;
    idle_pulse = 1'b1;
    @(negedge clk);
    chk("idle_resps", {30'b0, imem_resp, dmem_resp}, '0);
    chk("idle_rdata", imem_rdata | dmem_rdata, '0);
    chk("idle_masks", {28'b0, mem_rmask | mem_wmask}, '0);
    idle_pulse = 1'b0;
    @(negedge clk);
    chk("idle_addr", mem_addr, a0);
    chk("idle_wdata", mem_wdata, w0);
    chk("idle_masks2", {28'b0, mem_rmask | mem_wmask}, '0);

    // Reset in the middle of a dmem write
    @(posedge clk); #1;
    mem_lat = 3;
    dmem_addr = 32'h0000_2008;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wmask", {28'b0, mem_wmask}, 32'hF);
    chk("mid_resps", {30'b0, imem_resp, dmem_resp}, '0);
    rst = 1'b1;
    dmem_wmask = 4'h0;
    @(negedge clk);
    chk("mrst_masks", {24'b0, mem_rmask, mem_wmask}, '0);
    chk("mrst_addr", mem_addr, '0);
    chk("mrst_wdata", mem_wdata, '0);
    chk("mrst_resps", {30'b0, imem_resp, dmem_resp}, '0);
    rst = 1'b0;
    mem_lat = 1;
    @(posedge clk); #1;
    push(P_I, 32'h0000_1008, 4'hF, 4'h0, '0,
         mem_val(32'h0000_1008), -1);
    do_imem(32'h0000_1008);

    // Both requesting continuously
    repeat (2) @(posedge clk); #1;
    foreach (ord[j]) begin
      int gap;
      gap = (j == 0) ? -1 : 2;
      if (ord[j] >= 0)
        push(P_D, d_addr(ord[j]), d_rm(ord[j]), d_wm(ord[j]),
             d_wd(ord[j]), mem_val(d_addr(ord[j])), gap);
      else
        push(P_I, i_addr[-1 - ord[j]], 4'hF, 4'h0, '0,
             mem_val(i_addr[-1 - ord[j]]), gap);
    end
    fork
      begin
        for (int k = 0; k < 2; k++) do_imem(i_addr[k]);
      end
      begin
        for (int k = 0; k < 8; k++)
          do_dmem(d_addr(k), d_rm(k), d_wm(k), d_wd(k));
      end
    join

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the core's instruction port (imem) and data port (dmem).
- Sits between the cpu top level and the cache/memory model.
- Accepts requests in the same mask/resp protocol the core uses, and serialises them so only one transaction is outstanding downstream.
- Routes read data and response back to the requester that owns the current transaction.

Parameters:
- DMEM_STREAK_MAX, 4, consecutive dmem grants allowed while imem waits (used only with the optional feature).
- STREAK_W, 3, counter width; must satisfy 2**STREAK_W > DMEM_STREAK_MAX.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- imem_addr  in  32  instruction request address
- imem_rmask  in  4  instruction read mask; nonzero = request
- imem_rdata  out  32  instruction read data
- imem_resp  out  1  instruction transaction done
- dmem_addr  in  32  data request address
- dmem_rmask  in  4  data read mask
- dmem_wmask  in  4  data write mask
- dmem_wdata  in  32  data write data
- dmem_rdata  out  32  data read data
- dmem_resp  out  1  data transaction done
- mem_addr  out  32  downstream address
- mem_rmask  out  4  downstream read mask
- mem_wmask  out  4  downstream write mask
- mem_wdata  out  32  downstream write data
- mem_rdata  in  32  downstream read data
- mem_resp  in  1  downstream transaction done

Behaviour:
- Request protocol:
  - imem request = imem_rmask != 0.
  - dmem request = (dmem_rmask | dmem_wmask) != 0.
  - A requester holds its request fields stable until it sees its resp.
  - A requester changes or drops its request in the cycle after resp.
- FSM states: IDLE, IMEM, DMEM.
- IDLE:
  - No request: stay in IDLE.
  - dmem request present: go to DMEM; dmem has fixed priority because a dmem stall freezes the whole pipe.
  - Only imem request present: go to IMEM.
  - On the transition, register the winner's addr, rmask, wmask and wdata into the mem_* outputs. For imem, wmask=0 and wdata=0.
- IMEM / DMEM:
  - mem_* outputs are held constant until mem_resp=1.
  - While mem_resp=1, the owner's resp is 1 and its rdata = mem_rdata, both combinational in that same cycle; then go to IDLE.
  - In IDLE, all mem_* masks are 0, mem_addr and mem_wdata keep their last value, and both resps are 0.
- Non-owner outputs:
  - Non-owner resp is always 0.
  - Non-owner rdata is 0.
  - imem_rdata/dmem_rdata are 0 whenever their own resp is 0.
- Latency:
  - Request seen in IDLE at cycle N; downstream request visible from N+1.
  - Minimum round trip with a 1-cycle downstream memory: resp at N+1.
  - The next arbitration happens at N+2.
  - Back-to-back throughput is one transaction per 2 cycles minimum.
- Simultaneous imem and dmem requests in IDLE: dmem wins; imem waits, with its fields still held by the requester.
- mem_resp while in IDLE: ignored, with no resp forwarded. This is flagged by an assertion in simulation.
- A request dropped while it is owned is a protocol violation. The arbiter still completes the downstream transaction, and an assertion fires.
- Reset:
  - Takes effect in any state, including mid-transaction.
  - Results: state=IDLE, mem_addr=0, mem_rmask=0, mem_wmask=0, mem_wdata=0, imem_resp=0, dmem_resp=0, rdata outputs=0, streak counter=0.
  - An abandoned downstream transaction is dropped. The downstream side must also be reset by the same rst.

Optional Feature:
- Macro: MEM_ARB_ANTI_STARVE_EN.
- When defined:
  - A saturating streak counter increments on each dmem grant made while an imem request is pending.
  - It clears on any imem grant, and clears on any dmem grant made with no imem request pending.
  - When streak == DMEM_STREAK_MAX and both request in IDLE, imem wins.
- When not defined:
  - No counter is built, and dmem always has priority.
  - DMEM_STREAK_MAX and STREAK_W are unused.

Decomposition:
- Shared package (rv32imc_types) gets:
  - arb_state_t enum {ARB_IDLE, ARB_IMEM, ARB_DMEM};
  - mem_req_t struct {addr, rmask, wmask, wdata};
  - parameter ARB_NO_MASK = 4'b0.
- One natural sub-module: mem_arb_grant. It holds the combinational winner select plus the streak counter, takes the req/pending inputs, and outputs grant_imem/grant_dmem.
- The FSM and the output registers stay in the top.

Test Plan:
- Lone imem read at 0x0000_1000, rmask=4'hF, memory resp after 3 cycles with rdata 0x0000_0013 -> mem_rmask=F from N+1; imem_resp=1 and imem_rdata=0x0000_0013 in the resp cycle; dmem_resp stays 0.
- Simultaneous imem at 0x1004 and dmem write at 0x2000 (wmask=4'h3, wdata=0xDEAD_BEEF) -> dmem issued first with mem_wmask=3 and mem_wdata=0xDEADBEEF; imem issued in the cycle after IDLE is re-entered.
- Mem_resp pulsed while in IDLE with no request -> no resp on either side; outputs unchanged.
- Reset asserted mid DMEM transaction -> next cycle: IDLE, all masks 0, all resps 0; a later lone imem request is served normally.
- With MEM_ARB_ANTI_STARVE_EN and DMEM_STREAK_MAX=4: dmem and imem both continuously requesting -> grant order D,D,D,D,I,D,...
- Without MEM_ARB_ANTI_STARVE_EN, same stimulus -> imem never granted while dmem requests continuously.
